// File: rtl/oram_frontend_if.sv
// ORAM frontend bus bundle.
//
// Groups every handshake and data signal the frontend exchanges with its
// two neighbours: the user side (commands, store chunks, load chunks back
// to the user) and the backend side (issued commands with leaf labels,
// store chunks out, load chunks in). Clock and reset are not part of the
// bundle; they stay plain ports on the frontend.
//
// Modports:
//   slave  - the frontend's view (used by oram_frontend)
//   master - the environment's view (user plus backend)
//
// Signals (user side):   CmdIn, ProgAddrIn, CmdInValid/CmdInReady,
//                        DataIn, DataInValid/DataInReady,
//                        ReturnData, ReturnDataValid/ReturnDataReady
// Signals (backend side): CmdOut, AddrOut, OldLeaf, NewLeaf,
//                        CmdOutValid/CmdOutReady,
//                        StoreData, StoreDataValid/StoreDataReady,
//                        LoadData, LoadDataValid/LoadDataReady
interface oram_frontend_if #(
  parameter int ORAMU    = 32,
  parameter int ORAML    = 8,
  parameter int FEDWidth = 64
);

  logic [1:0]          CmdIn;
  logic [ORAMU-1:0]    ProgAddrIn;
  logic                CmdInValid;
  logic                CmdInReady;

  logic [FEDWidth-1:0] DataIn;
  logic                DataInValid;
  logic                DataInReady;

  logic [FEDWidth-1:0] ReturnData;
  logic                ReturnDataValid;
  logic                ReturnDataReady;

  logic [1:0]          CmdOut;
  logic [ORAMU-1:0]    AddrOut;
  logic [ORAML-1:0]    OldLeaf;
  logic [ORAML-1:0]    NewLeaf;
  logic                CmdOutValid;
  logic                CmdOutReady;

  logic [FEDWidth-1:0] StoreData;
  logic                StoreDataValid;
  logic                StoreDataReady;

  logic [FEDWidth-1:0] LoadData;
  logic                LoadDataValid;
  logic                LoadDataReady;

  modport slave (
    input  CmdIn, ProgAddrIn, CmdInValid,
    input  DataIn, DataInValid,
    input  ReturnDataReady,
    input  CmdOutReady,
    input  StoreDataReady,
    input  LoadData, LoadDataValid,
    output CmdInReady,
    output DataInReady,
    output ReturnData, ReturnDataValid,
    output CmdOut, AddrOut, OldLeaf, NewLeaf, CmdOutValid,
    output StoreData, StoreDataValid,
    output LoadDataReady
  );

  modport master (
    output CmdIn, ProgAddrIn, CmdInValid,
    output DataIn, DataInValid,
    output ReturnDataReady,
    output CmdOutReady,
    output StoreDataReady,
    output LoadData, LoadDataValid,
    input  CmdInReady,
    input  DataInReady,
    input  ReturnData, ReturnDataValid,
    input  CmdOut, AddrOut, OldLeaf, NewLeaf, CmdOutValid,
    input  StoreData, StoreDataValid,
    input  LoadDataReady
  );

endinterface

// File: rtl/oram_frontend.sv
// ORAM frontend: position map plus command/data sequencer.
//
// Accepts one user command at a time, looks up the leaf currently mapped
// to the block address, remaps the block to a fresh pseudo-random leaf,
// issues the command to the backend with both leaves, then passes one
// block's worth of data chunks (BC = ORAMB/FEDWidth) between user and
// backend in the direction the command implies.
//
// Ports:
//   Clock   - rising-edge clock
//   Reset   - asynchronous active-high reset; replays map initialisation
//   oramBus - oram_frontend_if.slave bundle with the user-side command,
//             store and return channels and the backend-side command,
//             store and load channels
module oram_frontend #(
  parameter int ORAMU         = 32,
  parameter int ORAML         = 8,
  parameter int ORAMB         = 512,
  parameter int FEDWidth      = 64,
  parameter int NumValidBlock = 256
) (
  input  logic            Clock,
  input  logic            Reset,
  oram_frontend_if.slave  oramBus
);

  localparam int IW = $clog2(NumValidBlock);
  localparam int BC = ORAMB / FEDWidth;
  localparam int CW = $clog2(BC + 1);

  localparam logic [IW-1:0] LastIdx   = IW'(NumValidBlock - 1);
  localparam logic [CW-1:0] LastChunk = CW'(BC - 1);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    ISSUE,
    DATA
  } state_t;

  state_t             state_q;
  logic [IW-1:0]      initIdx_q;
  logic [15:0]        lfsr_q;
  logic [15:0]        lfsr_d;
  logic [1:0]         cmd_q;
  logic [ORAMU-1:0]   addr_q;
  logic [ORAML-1:0]   oldLeaf_q;
  logic [ORAML-1:0]   newLeaf_q;
  logic               cmdInReady_q;
  logic               cmdOutValid_q;
  logic [CW-1:0]      chunkCnt_q;

  logic [ORAML-1:0]   posMap_q [NumValidBlock];

  logic               memWe;
  logic [IW-1:0]      memAddr;
  logic [ORAML-1:0]   memData;

  logic               storeActive;
  logic               loadActive;
  logic               chunkFire;

  // Fibonacci LFSR, taps 16,14,13,11; the leaf handed out is taken from
  // the value before this shift.
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Cmd bit 1 set means a load (Read/ReadRmv); clear means a store
  // (Update/Append). Only the matching direction is opened during DATA.
  assign storeActive = (state_q == DATA) && !cmd_q[1];
  assign loadActive  = (state_q == DATA) &&  cmd_q[1];

  assign chunkFire = (storeActive && oramBus.DataInValid   && oramBus.StoreDataReady) ||
                     (loadActive  && oramBus.LoadDataValid && oramBus.ReturnDataReady);

  assign oramBus.StoreData       = storeActive ? oramBus.DataIn : '0;
  assign oramBus.StoreDataValid  = storeActive && oramBus.DataInValid;
  assign oramBus.DataInReady     = storeActive && oramBus.StoreDataReady;

  assign oramBus.ReturnData      = loadActive ? oramBus.LoadData : '0;
  assign oramBus.ReturnDataValid = loadActive && oramBus.LoadDataValid;
  assign oramBus.LoadDataReady   = loadActive && oramBus.ReturnDataReady;

  assign oramBus.CmdInReady  = cmdInReady_q;
  assign oramBus.CmdOutValid = cmdOutValid_q;
  assign oramBus.CmdOut      = cmd_q;
  assign oramBus.AddrOut     = addr_q;
  assign oramBus.OldLeaf     = oldLeaf_q;
  assign oramBus.NewLeaf     = newLeaf_q;

  // The map has a single write port shared by initialisation (identity
  // fill, i mod 2^ORAML) and the remap done in LOOKUP.
  always_comb begin
    memWe   = 1'b0;
    memAddr = addr_q[IW-1:0];
    memData = newLeaf_q;
    if (state_q == INIT) begin
      memWe   = 1'b1;
      memAddr = initIdx_q;
      memData = ORAML'(initIdx_q);
    end else if (state_q == LOOKUP) begin
      memWe   = 1'b1;
    end
  end

  // No reset on the map itself: every reset passes through INIT, which
  // rewrites all entries before any command can be accepted.
  always_ff @(posedge Clock) begin
    if (memWe) begin
      posMap_q[memAddr] <= memData;
    end
  end

  // Sequencer. All handshake outputs except the data pass-through are
  // registered here and change together with the state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= INIT;
      initIdx_q     <= '0;
      lfsr_q        <= 16'hACE1;
      cmd_q         <= '0;
      addr_q        <= '0;
      oldLeaf_q     <= '0;
      newLeaf_q     <= '0;
      cmdInReady_q  <= 1'b0;
      cmdOutValid_q <= 1'b0;
      chunkCnt_q    <= '0;
    end else begin
      case (state_q)
        INIT: begin
          initIdx_q <= initIdx_q + IW'(1);
          if (initIdx_q == LastIdx) begin
            state_q      <= IDLE;
            cmdInReady_q <= 1'b1;
          end
        end

        IDLE: begin
          if (oramBus.CmdInValid) begin
            cmd_q        <= oramBus.CmdIn;
            addr_q       <= oramBus.ProgAddrIn;
            newLeaf_q    <= lfsr_q[ORAML-1:0];
            lfsr_q       <= lfsr_d;
            cmdInReady_q <= 1'b0;
            state_q      <= LOOKUP;
          end
        end

        // The read sees the entry before this edge's write, so OldLeaf is
        // the previous mapping while the map picks up newLeaf_q.
        LOOKUP: begin
          oldLeaf_q     <= posMap_q[addr_q[IW-1:0]];
          cmdOutValid_q <= 1'b1;
          state_q       <= ISSUE;
        end

        ISSUE: begin
          if (oramBus.CmdOutReady) begin
            cmdOutValid_q <= 1'b0;
            chunkCnt_q    <= '0;
            state_q       <= DATA;
          end
        end

        DATA: begin
          if (chunkFire) begin
            if (chunkCnt_q == LastChunk) begin
              chunkCnt_q   <= '0;
              cmdInReady_q <= 1'b1;
              state_q      <= IDLE;
            end else begin
              chunkCnt_q <= chunkCnt_q + CW'(1);
            end
          end
        end

        default: begin
          state_q <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oram_frontend.sv
// Directed testbench for oram_frontend with default parameters.
//
// Walks the frontend through map initialisation, each command type,
// backend command back-pressure, early store data, a toggling user
// ready on the return channel and a reset in the middle of a store.
// Leaf values are hand-computed from the LFSR sequence starting at
// 16'hACE1: E1, C3, 87, 0F, 1E, 3C.
module tb_oram_frontend;

  localparam int ORAMU    = 32;
  localparam int ORAML    = 8;
  localparam int FEDWidth = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int checkCount = 0;
  int failCount  = 0;

  // 10 ns clock period.
  always #5 clock = ~clock;

  oram_frontend_if #(.ORAMU(ORAMU), .ORAML(ORAML), .FEDWidth(FEDWidth)) oramBus ();

  oram_frontend #(
    .ORAMU(32),
    .ORAML(8),
    .ORAMB(512),
    .FEDWidth(64),
    .NumValidBlock(256)
  ) dut (
    .Clock(clock),
    .Reset(reset),
    .oramBus(oramBus)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Count cycles from reset release until the frontend is ready.
  task automatic waitInitDone();
    int cycles;
    bit seen;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 400) begin
      step();
      cycles++;
      if (oramBus.CmdInReady) seen = 1'b1;
    end
    checkOutput("initCycles", cycles, 256);
  endtask

  // Present a command until accepted; returns 1 ns after the accepting edge.
  task automatic applyStimulus(input logic [1:0] cmd, input logic [31:0] addr);
    int guard;
    guard = 0;
    oramBus.CmdIn      = cmd;
    oramBus.ProgAddrIn = addr;
    oramBus.CmdInValid = 1'b1;
    #1;
    while (!oramBus.CmdInReady && guard < 20) begin
      @(posedge clock);
      #2;
      guard++;
    end
    checkOutput("cmdAccept", oramBus.CmdInReady, 1);
    step();
    oramBus.CmdInValid = 1'b0;
  endtask

  // Wait for the backend command to appear.
  task automatic waitIssue();
    int guard;
    guard = 0;
    while (!oramBus.CmdOutValid && guard < 10) begin
      step();
      guard++;
    end
    checkOutput("cmdOutValid", oramBus.CmdOutValid, 1);
  endtask

  task automatic checkCommand(input logic [1:0] cmd, input logic [31:0] addr,
                              input logic [7:0] oldLeaf, input logic [7:0] newLeaf);
    checkOutput("cmdOut", oramBus.CmdOut, cmd);
    checkOutput("addrOut", oramBus.AddrOut, addr);
    checkOutput("oldLeaf", oramBus.OldLeaf, oldLeaf);
    checkOutput("newLeaf", oramBus.NewLeaf, newLeaf);
  endtask

  // Hold the backend off for ten cycles with load data on offer.
  task automatic holdStall(input logic [49:0] fields);
    for (int i = 0; i < 10; i++) begin
      oramBus.CmdOutReady     = 1'b0;
      oramBus.LoadDataValid   = 1'b1;
      oramBus.ReturnDataReady = 1'b1;
      #1;
      checkOutput("stallValid", oramBus.CmdOutValid, 1);
      checkOutput("stallFields",
                  {oramBus.CmdOut, oramBus.AddrOut, oramBus.OldLeaf, oramBus.NewLeaf}, fields);
      checkOutput("stallNoXfer", {oramBus.ReturnDataValid, oramBus.LoadDataReady,
                                  oramBus.StoreDataValid, oramBus.DataInReady}, 0);
      step();
    end
  endtask

  task automatic releaseCommand();
    oramBus.CmdOutReady = 1'b1;
    step();
    oramBus.CmdOutReady = 1'b0;
  endtask

  // Feed 8 load chunks; with toggle set the user ready alternates 0/1.
  task automatic loadBlock(input logic [63:0] base, input bit toggle);
    int xfers;
    int cyc;
    logic rdy;
    xfers = 0;
    cyc   = 0;
    while (xfers < 8 && cyc < 40) begin
      rdy = toggle ? cyc[0] : 1'b1;
      oramBus.LoadData        = base + 64'(xfers);
      oramBus.LoadDataValid   = 1'b1;
      oramBus.ReturnDataReady = rdy;
      #1;
      checkOutput("cmdInReadyBusy", oramBus.CmdInReady, 0);
      checkOutput("loadReadyMirror", oramBus.LoadDataReady, rdy);
      checkOutput("returnValid", oramBus.ReturnDataValid, 1);
      checkOutput("returnData", oramBus.ReturnData, base + 64'(xfers));
      checkOutput("storeClosed", {oramBus.StoreDataValid, oramBus.DataInReady}, 0);
      if (rdy) xfers++;
      cyc++;
      step();
    end
    oramBus.LoadDataValid   = 1'b0;
    oramBus.ReturnDataReady = 1'b0;
    checkOutput("loadXfers", xfers, 8);
    checkOutput("idleAfterLoad", oramBus.CmdInReady, 1);
  endtask

  // Push n store chunks, one per cycle, with load data also on offer.
  task automatic storeBlock(input logic [63:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      oramBus.DataIn         = base + 64'(k);
      oramBus.DataInValid    = 1'b1;
      oramBus.StoreDataReady = 1'b1;
      oramBus.LoadDataValid  = 1'b1;
      #1;
      checkOutput("storeData", oramBus.StoreData, base + 64'(k));
      checkOutput("storeValid", oramBus.StoreDataValid, 1);
      checkOutput("dataInReady", oramBus.DataInReady, 1);
      checkOutput("cmdInReadyBusy", oramBus.CmdInReady, 0);
      checkOutput("loadClosed", {oramBus.ReturnDataValid, oramBus.LoadDataReady}, 0);
      step();
    end
  endtask

  task automatic endStore();
    oramBus.DataInValid    = 1'b0;
    oramBus.StoreDataReady = 1'b0;
    oramBus.LoadDataValid  = 1'b0;
    checkOutput("idleAfterStore", oramBus.CmdInReady, 1);
  endtask

  // Safety net in case the DUT stalls somewhere unbounded.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    oramBus.CmdIn           = '0;
    oramBus.ProgAddrIn      = '0;
    oramBus.CmdInValid      = 1'b0;
    oramBus.DataIn          = '0;
    oramBus.DataInValid     = 1'b0;
    oramBus.ReturnDataReady = 1'b0;
    oramBus.CmdOutReady     = 1'b0;
    oramBus.StoreDataReady  = 1'b0;
    oramBus.LoadData        = '0;
    oramBus.LoadDataValid   = 1'b0;
    reset = 1'b1;

    repeat (3) step();
    #1;
    checkOutput("rstCmdInReady", oramBus.CmdInReady, 0);
    checkOutput("rstValids", {oramBus.CmdOutValid, oramBus.StoreDataValid,
                              oramBus.ReturnDataValid, oramBus.DataInReady,
                              oramBus.LoadDataReady}, 0);
    checkOutput("rstFields", {oramBus.CmdOut, oramBus.AddrOut,
                              oramBus.OldLeaf, oramBus.NewLeaf}, 0);
    step();
    reset = 1'b0;
    waitInitDone();

    $display("[TB] first read of address 0x5 with backend stall");
    applyStimulus(2'b10, 32'h5);
    waitIssue();
    checkCommand(2'b10, 32'h5, 8'h05, 8'hE1);
    holdStall({2'b10, 32'h5, 8'h05, 8'hE1});
    releaseCommand();
    loadBlock(64'hA5A5_0000_0000_0000, 1'b0);

    $display("[TB] update of address 0x5 with store data offered early");
    oramBus.DataIn         = 64'hC0DE_0000_0000_0000;
    oramBus.DataInValid    = 1'b1;
    oramBus.StoreDataReady = 1'b1;
    applyStimulus(2'b00, 32'h5);
    #1;
    checkOutput("earlyStoreStall", {oramBus.DataInReady, oramBus.StoreDataValid}, 0);
    waitIssue();
    checkOutput("issueStoreStall", {oramBus.DataInReady, oramBus.StoreDataValid}, 0);
    checkCommand(2'b00, 32'h5, 8'hE1, 8'hC3);
    releaseCommand();
    storeBlock(64'hC0DE_0000_0000_0000, 8);
    endStore();

    $display("[TB] read with upper address bits and toggling user ready");
    applyStimulus(2'b10, 32'hABCD_0005);
    waitIssue();
    checkCommand(2'b10, 32'hABCD_0005, 8'hC3, 8'h87);
    releaseCommand();
    loadBlock(64'h1111_2222_0000_0000, 1'b1);

    $display("[TB] append to address 0x7");
    applyStimulus(2'b01, 32'h7);
    waitIssue();
    checkCommand(2'b01, 32'h7, 8'h07, 8'h0F);
    releaseCommand();
    storeBlock(64'h7777_0000_0000_0010, 8);
    endStore();

    $display("[TB] readrmv of address 0x100 (index 0)");
    applyStimulus(2'b11, 32'h100);
    waitIssue();
    checkCommand(2'b11, 32'h100, 8'h00, 8'h1E);
    releaseCommand();
    loadBlock(64'hFFFF_0000_0000_0100, 1'b0);

    $display("[TB] reset in the middle of a store");
    applyStimulus(2'b00, 32'h9);
    waitIssue();
    checkCommand(2'b00, 32'h9, 8'h09, 8'h3C);
    releaseCommand();
    storeBlock(64'h9999_0000_0000_0000, 3);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midRstValids", {oramBus.CmdOutValid, oramBus.StoreDataValid,
                                 oramBus.ReturnDataValid, oramBus.DataInReady,
                                 oramBus.LoadDataReady, oramBus.CmdInReady}, 0);
    checkOutput("midRstFields", {oramBus.CmdOut, oramBus.AddrOut,
                                 oramBus.OldLeaf, oramBus.NewLeaf}, 0);
    oramBus.DataInValid    = 1'b0;
    oramBus.StoreDataReady = 1'b0;
    oramBus.LoadDataValid  = 1'b0;
    step();
    step();
    reset = 1'b0;
    waitInitDone();

    applyStimulus(2'b10, 32'h9);
    waitIssue();
    checkCommand(2'b10, 32'h9, 8'h09, 8'hE1);
    releaseCommand();
    loadBlock(64'h0BAD_0000_0000_0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
